// File: rtl/main_decode_stage.sv
// Registered ID/EX control stage: decodes LANES opcodes per beat into 14-bit control bundles,
// with valid/ready handshake, stall, flush and a saturating illegal-opcode counter.
module main_decode_stage #(
    parameter int LANES    = 1,
    parameter int EN_AUIPC = 1,
    parameter int CNT_W    = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [7*LANES-1:0]    op_in,
    input  logic                  stall,
    input  logic                  flush,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [14*LANES-1:0]   ctrl_out,
    output logic                  illegal_seen,
    output logic [CNT_W-1:0]      illegal_cnt
);

    localparam int PW = $clog2(LANES + 1);
    localparam int SW = CNT_W + PW;
    localparam logic [SW-1:0] CNT_MAX = SW'({CNT_W{1'b1}});

    // Bundle layout: {RW, RS[1:0], MW, J[1:0], AS, IS[2:0], Lui, Auipc, Br, Ill}
    function automatic logic [13:0] decode_op(input logic [6:0] op);
        logic [13:0] d;
        d = 14'b0;
        case (op)
            7'b0110011: d = 14'b1_00_0_00_0_000_0000;
            7'b0010011: d = 14'b1_00_0_00_1_000_0000;
            7'b0000011: d = 14'b1_01_0_00_1_000_0000;
            7'b1100111: d = 14'b1_10_0_11_1_000_0000;
            7'b0100011: d = 14'b0_00_1_00_1_001_0000;
            7'b1101111: d = 14'b1_10_0_10_0_100_0000;
            7'b1100011: d = 14'b0_00_0_00_0_010_0010;
            7'b0110111: d = 14'b1_11_0_00_0_011_1000;
            7'b0010111: begin
                if (EN_AUIPC != 0) d = 14'b1_11_0_00_0_011_0100;
                else               d = 14'b0_00_0_00_0_000_0001;
            end
            default:    d = 14'b0_00_0_00_0_000_0001;
        endcase
        return d;
    endfunction

    logic [14*LANES-1:0] dec_all;
    logic [PW-1:0]       ill_count;
    logic [SW-1:0]       cnt_sum;
    logic                accept;

    always_comb begin
        dec_all   = '0;
        ill_count = '0;
        for (int i = 0; i < LANES; i++) begin
            dec_all[14*i +: 14] = decode_op(op_in[7*i +: 7]);
            ill_count = ill_count + PW'(dec_all[14*i]);
        end
    end

    assign in_ready = !stall && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready && !flush;
    assign cnt_sum  = SW'(illegal_cnt) + SW'(ill_count);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid    <= 1'b0;
            ctrl_out     <= '0;
            illegal_seen <= 1'b0;
            illegal_cnt  <= '0;
        end else if (flush) begin
            // Dropped beat never reaches the counters
            out_valid <= 1'b0;
            ctrl_out  <= '0;
        end else if (accept) begin
            out_valid <= 1'b1;
            ctrl_out  <= dec_all;
            if (ill_count != '0) illegal_seen <= 1'b1;
            if (cnt_sum > CNT_MAX) illegal_cnt <= CNT_MAX[CNT_W-1:0];
            else                   illegal_cnt <= cnt_sum[CNT_W-1:0];
        end else if (out_valid && out_ready && !stall) begin
            out_valid <= 1'b0;
        end
    end

endmodule
